// File: rtl/irq_service_seq.sv
// rtl/irq_service_seq.sv - settle/request/clear sequencer behind the 27-channel interrupt decoder
// Optional ack timeout is built when IRQ_TIMEOUT_EN is defined.
module irq_service_seq #(
    parameter int STABLE_CYC = 2,
    parameter int CLR_CYC    = 1
`ifdef IRQ_TIMEOUT_EN
    ,
    parameter int TO_CYC     = 255
`endif
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        pa,
    input  logic        pb,
    input  logic        pc,
    input  logic [3:0]  chan,
    input  logic        ack,
    output logic        irq,
    output logic [5:0]  vec,
    output logic [26:0] clr,
    output logic        busy,
    output logic        err,
    output logic        tout
);

    typedef enum logic [2:0] {IDLE, SETTLE, REQ, CLEAR, HOLD} state_t;

    localparam logic [3:0] STABLE_L = 4'(STABLE_CYC);
    localparam logic [3:0] CLR_L    = 4'(CLR_CYC);

    state_t      state, state_n;
    logic [5:0]  sample, sample_n, vec_n;
    logic [3:0]  cnt, cnt_n;
    logic        irq_n, err_n;
    logic [26:0] clr_n;
    logic [1:0]  bus;
    logic [5:0]  code;
    logic [4:0]  idx;

`ifdef IRQ_TIMEOUT_EN
    localparam logic [7:0] TO_L = 8'(TO_CYC);
    logic [7:0] to_cnt, to_cnt_n;
    logic       tout_n;
`endif

    always_comb begin
        bus  = pa ? 2'd1 : pb ? 2'd2 : pc ? 2'd3 : 2'd0;
        code = {bus, chan};
    end

    // Flat clear index from the latched vector: (bus-1)*9 + chan
    always_comb begin
        case (vec[5:4])
            2'd2:    idx = 5'd9 + {1'b0, vec[3:0]};
            2'd3:    idx = 5'd18 + {1'b0, vec[3:0]};
            default: idx = {1'b0, vec[3:0]};
        endcase
    end

    always_comb begin
        state_n  = state;
        sample_n = sample;
        cnt_n    = cnt;
        vec_n    = vec;
        irq_n    = irq;
        clr_n    = clr;
        err_n    = 1'b0;
`ifdef IRQ_TIMEOUT_EN
        to_cnt_n = to_cnt;
        tout_n   = tout;
`endif
        case (state)
            IDLE: begin
                if (bus != 2'd0) begin
                    state_n  = SETTLE;
                    sample_n = code;
                    cnt_n    = 4'd1;
                end
            end
            SETTLE: begin
                if (bus == 2'd0) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt >= STABLE_L) begin
                    // The stored sample has been seen STABLE_CYC times in a row
                    cnt_n = 4'd0;
                    if (sample[3:0] > 4'd8) begin
                        err_n   = 1'b1;
                        state_n = HOLD;
                    end else begin
                        vec_n   = sample;
                        irq_n   = 1'b1;
                        state_n = REQ;
`ifdef IRQ_TIMEOUT_EN
                        to_cnt_n = 8'd0;
`endif
                    end
                end else if (code == sample) begin
                    cnt_n = cnt + 4'd1;
                end else begin
                    sample_n = code;
                    cnt_n    = 4'd1;
                end
            end
            REQ: begin
                if (ack) begin
                    irq_n   = 1'b0;
                    clr_n   = 27'd1 << idx;
                    cnt_n   = 4'd1;
                    state_n = CLEAR;
                end
`ifdef IRQ_TIMEOUT_EN
                else if (to_cnt == TO_L - 8'd1) begin
                    irq_n   = 1'b0;
                    tout_n  = 1'b1;
                    clr_n   = 27'd1 << idx;
                    cnt_n   = 4'd1;
                    state_n = CLEAR;
                end else begin
                    to_cnt_n = to_cnt + 8'd1;
                end
`endif
            end
            CLEAR: begin
                if (cnt >= CLR_L) begin
                    clr_n   = 27'd0;
                    cnt_n   = 4'd0;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            HOLD: begin
                // Wait for the decoder to drop the serviced source before rearming
                if (!ack && bus == 2'd0) begin
                    state_n = IDLE;
                    vec_n   = 6'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sample <= 6'd0;
            cnt    <= 4'd0;
            vec    <= 6'd0;
            irq    <= 1'b0;
            clr    <= 27'd0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            sample <= sample_n;
            cnt    <= cnt_n;
            vec    <= vec_n;
            irq    <= irq_n;
            clr    <= clr_n;
            err    <= err_n;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            to_cnt <= 8'd0;
            tout   <= 1'b0;
        end else begin
            to_cnt <= to_cnt_n;
            tout   <= tout_n;
        end
    end
`else
    assign tout = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_irq_service_seq.sv
// tb/tb_irq_service_seq.sv - vector table, directed corner cases and random transactions for irq_service_seq
module tb_irq_service_seq;

    localparam int STABLE = 2;
    localparam int CLRC   = 1;

    logic        ck = 1'b0;
    logic        rst;
    logic        pa, pb, pc, ack;
    logic [3:0]  chan;
    logic        irq, busy, err, tout;
    logic [5:0]  vec;
    logic [26:0] clr;

    int total = 0;
    int bad   = 0;

    always #5 ck = ~ck;

    irq_service_seq #(
        .STABLE_CYC(STABLE),
        .CLR_CYC   (CLRC)
`ifdef IRQ_TIMEOUT_EN
        ,
        .TO_CYC    (4)
`endif
    ) dut (
        .ck  (ck),
        .rst (rst),
        .pa  (pa),
        .pb  (pb),
        .pc  (pc),
        .chan(chan),
        .ack (ack),
        .irq (irq),
        .vec (vec),
        .clr (clr),
        .busy(busy),
        .err (err),
        .tout(tout)
    );

    typedef struct {
        logic [2:0]  f;
        logic [3:0]  c;
        logic        a;
        logic        irq;
        logic [5:0]  vec;
        logic [26:0] clr;
        logic        busy;
        logic        err;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic [2:0] f, input logic [3:0] c, input logic a,
                                input logic i, input logic [5:0] v, input logic [26:0] cl,
                                input logic b, input logic e);
        row_t r;
        r.f = f; r.c = c; r.a = a; r.irq = i; r.vec = v; r.clr = cl; r.busy = b; r.err = e;
        return r;
    endfunction

    // Reference rules: bus priority A>B>C, flat clear index (bus-1)*9+chan
    function automatic logic [1:0] busof(input logic [2:0] f);
        return f[2] ? 2'd1 : f[1] ? 2'd2 : f[0] ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [26:0] onehot(input logic [1:0] b, input logic [3:0] c);
        int n;
        n = (int'(b) - 1) * 9 + int'(c);
        return 27'd1 << n;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [3:0] c, input logic a);
        {pa, pb, pc} = f;
        chan = c;
        ack  = a;
    endtask

    task automatic wait_irq(input string name);
        int n;
        n = 0;
        while (!irq && n < 20) begin
            tick;
            n++;
        end
        chk(name, {31'd0, irq}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f, gf;
        logic [3:0]  c, gc;
        logic [1:0]  b;
        logic [26:0] oh;
        int          lat, d;
        logic        early, glitch;

        rst = 1'b1;
        drive(3'b000, 4'd0, 1'b0);
        #2;
        chk("reset outputs", {irq, vec, clr, busy, err, tout}, 32'd0);
        @(negedge ck);
        rst = 1'b0;
        tick;
        chk("idle after reset", {31'd0, busy}, 32'd0);

        // Reset in the middle of a request
        drive(3'b100, 4'd3, 1'b0);
        wait_irq("midreq irq");
        #2;
        rst = 1'b1;
        #1;
        chk("midreq async clear", {irq, vec, clr, busy, err, tout}, 32'd0);
        drive(3'b000, 4'd0, 1'b0);
        @(negedge ck);
        rst = 1'b0;
        tick;
        chk("midreq idle after release", {25'd0, busy, vec}, 32'd0);

        // Nominal B5
        tbl.push_back(mk(3'b010, 4'd5,  1'b0, 1'b0, 6'd0,         27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b010, 4'd5,  1'b0, 1'b0, 6'd0,         27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b010, 4'd5,  1'b0, 1'b1, 6'b10_0101,   27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b010, 4'd5,  1'b1, 1'b0, 6'b10_0101,   27'd1 << 14, 1'b1, 1'b0));
        tbl.push_back(mk(3'b010, 4'd5,  1'b1, 1'b0, 6'b10_0101,   27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0,  1'b0, 1'b0, 6'd0,         27'd0,      1'b0, 1'b0));
        // Priority with a glitching channel
        tbl.push_back(mk(3'b110, 4'd2,  1'b0, 1'b0, 6'd0,         27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b110, 4'd7,  1'b0, 1'b0, 6'd0,         27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b110, 4'd7,  1'b0, 1'b0, 6'd0,         27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b110, 4'd7,  1'b0, 1'b1, 6'b01_0111,   27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b110, 4'd7,  1'b1, 1'b0, 6'b01_0111,   27'd1 << 7, 1'b1, 1'b0));
        tbl.push_back(mk(3'b110, 4'd7,  1'b1, 1'b0, 6'b01_0111,   27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0,  1'b0, 1'b0, 6'd0,         27'd0,      1'b0, 1'b0));
        // Invalid channel on bus C
        tbl.push_back(mk(3'b001, 4'd12, 1'b0, 1'b0, 6'd0,         27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b001, 4'd12, 1'b0, 1'b0, 6'd0,         27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b001, 4'd12, 1'b0, 1'b0, 6'd0,         27'd0,      1'b1, 1'b1));
        tbl.push_back(mk(3'b001, 4'd12, 1'b0, 1'b0, 6'd0,         27'd0,      1'b1, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0,  1'b0, 1'b0, 6'd0,         27'd0,      1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].f, tbl[i].c, tbl[i].a);
            tick;
            chk($sformatf("row%0d", i), {irq, vec, clr, busy, err},
                {tbl[i].irq, tbl[i].vec, tbl[i].clr, tbl[i].busy, tbl[i].err});
        end

        // Hold-off: source still asserted after clear must not be re-serviced
        drive(3'b100, 4'd0, 1'b0);
        wait_irq("holdoff first irq");
        drive(3'b100, 4'd0, 1'b1);
        tick;
        chk("holdoff first clr", clr, 32'd1);
        drive(3'b100, 4'd0, 1'b0);
        early = 1'b0;
        repeat (6) begin
            tick;
            early |= irq | (|clr);
        end
        chk("holdoff no reservice", {31'd0, early}, 32'd0);
        chk("holdoff busy", {31'd0, busy}, 32'd1);
        drive(3'b000, 4'd0, 1'b0);
        tick;
        chk("holdoff released", {31'd0, busy}, 32'd0);
        drive(3'b100, 4'd0, 1'b0);
        wait_irq("holdoff second irq");
        drive(3'b100, 4'd0, 1'b1);
        tick;
        chk("holdoff second clr", clr, 32'd1);
        drive(3'b000, 4'd0, 1'b0);
        tick;
        tick;
        chk("holdoff idle", {31'd0, busy}, 32'd0);

        // Random transactions against the service rules
        for (int it = 0; it < 60; it++) begin
            f = 3'($urandom_range(1, 7));
            c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            b = busof(f);
            glitch = 1'($urandom_range(0, 1));
            lat = STABLE + 1;
            early = 1'b0;
            if (glitch) begin
                gf = 3'($urandom_range(1, 7));
                gc = 4'($urandom_range(0, 15));
                if ({busof(gf), gc} != {b, c}) lat = STABLE + 2;
                drive(gf, gc, 1'($urandom_range(0, 1)));
                tick;
                early |= irq | err;
            end
            for (int t = (glitch ? 2 : 1); t <= lat; t++) begin
                drive(f, c, 1'($urandom_range(0, 1)));
                tick;
                if (t < lat) early |= irq | err;
            end
            chk($sformatf("rnd%0d early", it), {31'd0, early}, 32'd0);
            if (c > 4'd8) begin
                chk($sformatf("rnd%0d err", it), {irq, err}, 32'd1);
                tick;
                chk($sformatf("rnd%0d hold", it), {irq, err, busy, clr}, {2'b00, 1'b1, 27'd0});
                drive(3'b000, 4'd0, 1'b0);
                tick;
                chk($sformatf("rnd%0d idle", it), {25'd0, busy, vec}, 32'd0);
            end else begin
                chk($sformatf("rnd%0d req", it), {err, irq, vec}, {1'b0, 1'b1, b, c});
                d = $urandom_range(0, 3);
                repeat (d) begin
                    drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0);
                    tick;
                    chk($sformatf("rnd%0d hold vec", it), {irq, vec}, {1'b1, b, c});
                end
                oh = onehot(b, c);
                drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b1);
                tick;
                chk($sformatf("rnd%0d clr", it), {irq, clr}, {1'b0, oh});
                for (int k = 1; k < CLRC; k++) begin
                    tick;
                    chk($sformatf("rnd%0d clr width", it), clr, oh);
                end
                drive(3'b000, 4'd0, 1'b0);
                tick;
                chk($sformatf("rnd%0d clr end", it), {busy, clr}, {1'b1, 27'd0});
                tick;
                chk($sformatf("rnd%0d idle", it), {25'd0, busy, vec}, 32'd0);
            end
        end

`ifdef IRQ_TIMEOUT_EN
        // Ack on the same cycle as the timeout limit wins
        drive(3'b001, 4'd8, 1'b0);
        wait_irq("to ack irq");
        repeat (3) begin
            tick;
            chk("to ack irq held", {31'd0, irq}, 32'd1);
        end
        drive(3'b001, 4'd8, 1'b1);
        tick;
        chk("to ack path", {irq, tout, clr}, {2'b00, 27'd1 << 26});
        drive(3'b000, 4'd0, 1'b0);
        tick;
        tick;
        chk("to ack idle", {30'd0, busy, tout}, 32'd0);
        // No ack: request times out after 4 cycles
        drive(3'b001, 4'd8, 1'b0);
        wait_irq("to irq");
        repeat (3) begin
            tick;
            chk("to irq held", {31'd0, irq}, 32'd1);
        end
        tick;
        chk("to expired", {irq, tout, clr}, {2'b01, 27'd1 << 26});
        drive(3'b000, 4'd0, 1'b0);
        tick;
        tick;
        chk("to sticky", {30'd0, busy, tout}, 32'd1);
`else
        chk("tout tied low", {31'd0, tout}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
